datapath: RTL and testbench

- 16-bit execution datapath of the simple RISC machine.
- Contains an 8x16 register file, operand registers A/B, a 1-bit shifter, operand-select muxes, a 4-op ALU, result register C and a 3-bit status register.
- Driven cycle-by-cycle by the controller FSM; result goes to memory/write-back.

---
 rtl/datapath_if.sv | 33 +++
 rtl/datapath.sv | 102 ++++++++++
 tb/tb_datapath.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/datapath_if.sv
// Control and data bundle between the sequencing FSM (master) and the execution datapath (slave).
interface datapath_if;
    logic [2:0]  readnum;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic [2:0]  writenum;
    logic        write;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [7:0]  PC;
    logic [15:0] mdata;
    logic [2:0]  status_out;
    logic [15:0] datapath_out;

    modport master (
        output readnum, vsel, loada, loadb, shift, asel, bsel, ALUop,
               loadc, loads, writenum, write, sximm8, sximm5, PC, mdata,
        input  status_out, datapath_out
    );

    modport slave (
        input  readnum, vsel, loada, loadb, shift, asel, bsel, ALUop,
               loadc, loads, writenum, write, sximm8, sximm5, PC, mdata,
        output status_out, datapath_out
    );
endinterface

// File: rtl/datapath.sv
// 16-bit execution datapath: 8x16 register file, A/B operand registers, shifter,
// 4-op ALU, result register C and {N,V,Z} status register.
module datapath (
    input  logic         clk,
    input  logic         reset,
    datapath_if.slave    dp
);
    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] c_q, c_d;
    logic [2:0]  status_q, status_d;

    logic [15:0] data_in;
    logic [15:0] read_data;
    logic [15:0] b_shifted;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [15:0] alu_out;
    logic        flag_n;
    logic        flag_v;
    logic        flag_z;

    always_comb begin
        data_in = c_q;
        case (dp.vsel)
            2'b00:   data_in = c_q;
            2'b01:   data_in = {8'b0, dp.PC};
            2'b10:   data_in = dp.sximm8;
            default: data_in = dp.mdata;
        endcase
    end

    // Read comes from stored contents, so a same-cycle write to readnum returns the old value.
    assign read_data = regs_q[dp.readnum];

    always_comb begin
        b_shifted = b_q;
        case (dp.shift)
            2'b00:   b_shifted = b_q;
            2'b01:   b_shifted = {b_q[14:0], 1'b0};
            2'b10:   b_shifted = {1'b0, b_q[15:1]};
            default: b_shifted = {b_q[15], b_q[15:1]};
        endcase
    end

    assign ain = dp.asel ? 16'b0 : a_q;
    assign bin = dp.bsel ? dp.sximm5 : b_shifted;

    always_comb begin
        alu_out = 16'b0;
        flag_v  = 1'b0;
        case (dp.ALUop)
            2'b00: begin
                alu_out = ain + bin;
                flag_v  = (ain[15] == bin[15]) && (alu_out[15] != ain[15]);
            end
            2'b01: begin
                alu_out = ain - bin;
                flag_v  = (ain[15] != bin[15]) && (alu_out[15] != ain[15]);
            end
            2'b10:   alu_out = ain & bin;
            default: alu_out = ~bin;
        endcase
    end

    assign flag_n = alu_out[15];
    assign flag_z = (alu_out == 16'b0);

    always_comb begin
        regs_d = regs_q;
        if (dp.write) begin
            regs_d[dp.writenum] = data_in;
        end
        a_d      = dp.loada ? read_data : a_q;
        b_d      = dp.loadb ? read_data : b_q;
        c_d      = dp.loadc ? alu_out : c_q;
        status_d = dp.loads ? {flag_n, flag_v, flag_z} : status_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'b0;
            end
            a_q      <= 16'b0;
            b_q      <= 16'b0;
            c_q      <= 16'b0;
            status_q <= 3'b0;
        end else begin
            regs_q   <= regs_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            status_q <= status_d;
        end
    end

    assign dp.datapath_out = c_q;
    assign dp.status_out   = status_q;
endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath: register file, shifter, ALU, flags and async reset.
module tb_datapath;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    datapath_if dif ();

    datapath dut (
        .clk   (clk),
        .reset (reset),
        .dp    (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        dif.loada = 1'b0;
        dif.loadb = 1'b0;
        dif.loadc = 1'b0;
        dif.loads = 1'b0;
        dif.write = 1'b0;
    endtask

    task automatic wr_imm(input logic [2:0] n, input logic [15:0] v);
        dif.vsel     = 2'b10;
        dif.sximm8   = v;
        dif.writenum = n;
        dif.write    = 1'b1;
        tick();
    endtask

    task automatic ld(input logic is_a, input logic [2:0] n);
        dif.readnum = n;
        if (is_a) dif.loada = 1'b1;
        else      dif.loadb = 1'b1;
        tick();
    endtask

    task automatic alu(input logic [1:0] sh, input logic as, input logic bs,
                       input logic [1:0] op, input logic lc, input logic ls);
        dif.shift = sh;
        dif.asel  = as;
        dif.bsel  = bs;
        dif.ALUop = op;
        dif.loadc = lc;
        dif.loads = ls;
        tick();
    endtask

    task automatic read_reg(input logic [2:0] n, input logic [15:0] exp, input string tag);
        ld(1'b0, n);
        alu(2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        chk(tag, dif.datapath_out, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        dif.readnum  = 3'd0;
        dif.vsel     = 2'b00;
        dif.loada    = 1'b0;
        dif.loadb    = 1'b0;
        dif.shift    = 2'b00;
        dif.asel     = 1'b0;
        dif.bsel     = 1'b0;
        dif.ALUop    = 2'b00;
        dif.loadc    = 1'b0;
        dif.loads    = 1'b0;
        dif.writenum = 3'd0;
        dif.write    = 1'b0;
        dif.sximm8   = 16'd0;
        dif.sximm5   = 16'd0;
        dif.PC       = 8'd0;
        dif.mdata    = 16'd0;
        reset        = 1'b1;

        @(posedge clk);
        #1;
        chk("reset_c", dif.datapath_out, 16'h0000);
        chk("reset_status", {13'b0, dif.status_out}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // MOV then ADD with LSL on B
        wr_imm(3'd0, 16'd7);
        wr_imm(3'd1, 16'd2);
        ld(1'b0, 3'd0);
        ld(1'b1, 3'd1);
        alu(2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        chk("add_lsl", dif.datapath_out, 16'd16);
        dif.vsel = 2'b00; dif.writenum = 3'd2; dif.write = 1'b1;
        tick();
        read_reg(3'd2, 16'd16, "wb_c_r2");

        // SUB with LSR, zero flag
        wr_imm(3'd3, 16'd32);
        ld(1'b0, 3'd3);
        ld(1'b1, 3'd2);
        alu(2'b10, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1);
        chk("sub_lsr_c", dif.datapath_out, 16'h0000);
        chk("sub_lsr_status", {13'b0, dif.status_out}, 16'h0001);

        // AND and MVN, status held
        wr_imm(3'd5, 16'hFFCE);
        ld(1'b1, 3'd5);
        ld(1'b0, 3'd0);
        alu(2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        chk("and_c", dif.datapath_out, 16'h0006);
        chk("and_status_hold", {13'b0, dif.status_out}, 16'h0001);
        alu(2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
        chk("mvn_c", dif.datapath_out, 16'hFFF8);
        chk("mvn_status_hold", {13'b0, dif.status_out}, 16'h0001);

        // Immediate path
        dif.sximm5 = 16'd16;
        alu(2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
        chk("imm_add", dif.datapath_out, 16'd16);

        // Negative flag only, C unchanged
        wr_imm(3'd4, 16'd100);
        ld(1'b0, 3'd4);
        alu(2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
        chk("neg_status", {13'b0, dif.status_out}, 16'h0004);
        chk("neg_c_hold", dif.datapath_out, 16'd16);

        // 0 - 0x8000 overflows
        wr_imm(3'd6, 16'h8000);
        ld(1'b0, 3'd6);
        alu(2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
        chk("sub_ovf_c", dif.datapath_out, 16'h8000);
        chk("sub_ovf_status", {13'b0, dif.status_out}, 16'h0006);

        // ASR and LSR on a negative value
        alu(2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        chk("asr_c", dif.datapath_out, 16'hC000);
        chk("asr_status", {13'b0, dif.status_out}, 16'h0004);
        alu(2'b10, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        chk("lsr_c", dif.datapath_out, 16'h4000);
        chk("lsr_status", {13'b0, dif.status_out}, 16'h0000);

        // Add overflow: 0x7FFF + 1
        wr_imm(3'd7, 16'h7FFF);
        ld(1'b1, 3'd7);
        dif.sximm5 = 16'd1;
        alu(2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1);
        chk("add_ovf_c", dif.datapath_out, 16'h8000);
        chk("add_ovf_status", {13'b0, dif.status_out}, 16'h0006);

        // Same-cycle write/read returns old value
        dif.readnum  = 3'd1;
        dif.loadb    = 1'b1;
        dif.vsel     = 2'b10;
        dif.sximm8   = 16'd9;
        dif.writenum = 3'd1;
        dif.write    = 1'b1;
        tick();
        alu(2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        chk("rw_same_old", dif.datapath_out, 16'd2);
        read_reg(3'd1, 16'd9, "rw_same_new");

        // PC and mdata write-back
        dif.vsel = 2'b01; dif.PC = 8'hAB; dif.writenum = 3'd3; dif.write = 1'b1;
        tick();
        read_reg(3'd3, 16'h00AB, "wb_pc");
        dif.vsel = 2'b11; dif.mdata = 16'hBEEF; dif.writenum = 3'd4; dif.write = 1'b1;
        tick();
        read_reg(3'd4, 16'hBEEF, "wb_mdata");

        // Load nonzero status then reset between edges
        ld(1'b0, 3'd6);
        alu(2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
        chk("pre_reset_status", {13'b0, dif.status_out}, 16'h0006);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_c", dif.datapath_out, 16'h0000);
        chk("async_reset_status", {13'b0, dif.status_out}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), 16'h0000, $sformatf("reset_r%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
